// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for one synchronised push-button level.
module btn_edge
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  // One event per press; holding the button produces nothing more.
  assign evt = btn & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run control, prescaler, lap capture and display mux for a 00..99 BCD stopwatch.
// Define STOPWATCH_AUTOSTOP_EN to stop at 99 instead of wrapping to 00.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int DIV_W = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       LAP,
  input  logic       CLR,
  input  logic [3:0] CNT1,
  input  logic [3:0] CNT10,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic [3:0] DISP1,
  output logic [3:0] DISP10,
  output logic       RUNNING,
  output logic       LAP_HOLD,
  output logic [1:0] STATE
);

  logic start_evt, lap_evt, clr_evt;
  logic do_start, do_lap, do_clr;
  logic active, counting, wrap, autostop;
  logic [DIV_W-1:0] presc;
  bcd_t lap1, lap10;
  state_t state, state_nx;

  btn_edge u_start (.clk(CLK), .rst(RST), .btn(START), .evt(start_evt));
  btn_edge u_lap   (.clk(CLK), .rst(RST), .btn(LAP),   .evt(lap_evt));
  btn_edge u_clr   (.clk(CLK), .rst(RST), .btn(CLR),   .evt(clr_evt));

  // Same-cycle priority CLR > START > LAP.
  assign do_clr   = clr_evt;
  assign do_start = start_evt & ~clr_evt;
  assign do_lap   = lap_evt & ~clr_evt & ~start_evt;

  assign active = (state == stopwatch_pkg::RUN) || (state == stopwatch_pkg::LAP);
  // Prescaler freezes on the edge that leaves RUN/LAP, so a resume finishes the partial tick.
  assign counting = active & ~do_clr & ~do_start;
  assign wrap     = counting & (presc == DIV_W'(DIV - 1));

`ifdef STOPWATCH_AUTOSTOP_EN
  assign autostop = wrap & (CNT10 == BCD_MAX) & (CNT1 == BCD_MAX);
`else
  assign autostop = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= stopwatch_pkg::IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (do_clr) begin
      state_nx = stopwatch_pkg::IDLE;
    end else if (autostop) begin
      state_nx = stopwatch_pkg::STOP;
    end else begin
      case (state)
        stopwatch_pkg::IDLE: if (do_start) state_nx = stopwatch_pkg::RUN;
        stopwatch_pkg::RUN: begin
          if (do_start)    state_nx = stopwatch_pkg::STOP;
          else if (do_lap) state_nx = stopwatch_pkg::LAP;
        end
        stopwatch_pkg::LAP: begin
          if (do_start)    state_nx = stopwatch_pkg::STOP;
          else if (do_lap) state_nx = stopwatch_pkg::RUN;
        end
        stopwatch_pkg::STOP: if (do_start) state_nx = stopwatch_pkg::RUN;
        default: state_nx = stopwatch_pkg::IDLE;
      endcase
    end
  end

  always_comb begin
    RUNNING  = active;
    LAP_HOLD = (state == stopwatch_pkg::LAP);
    STATE    = state;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      CNT_EN  <= 1'b0;
      CNT_CLR <= 1'b0;
      lap1    <= '0;
      lap10   <= '0;
    end else begin
      CNT_CLR <= do_clr;
      CNT_EN  <= wrap & ~autostop;
      if (do_clr || wrap) presc <= '0;
      else if (counting)  presc <= presc + DIV_W'(1);
      if ((state == stopwatch_pkg::RUN) && do_lap) begin
        lap1  <= CNT1;
        lap10 <= CNT10;
      end
    end
  end

  assign DISP1  = LAP_HOLD ? lap1  : CNT1;
  assign DISP10 = LAP_HOLD ? lap10 : CNT10;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a behavioural BCD counter closing the loop.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, lap = 1'b0, clr = 1'b0;
  logic [3:0] cnt1, cnt10, disp1, disp10;
  logic cnt_en, cnt_clr, running, lap_hold;
  logic [1:0] state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_ticks = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic s, l, c;
    logic run, hold;
    logic [1:0] st;
    logic cc;
  } vec_t;
  vec_t vecs[18];

  stopwatch_ctrl #(.DIV(DIV), .DIV_W(16)) dut (
    .CLK(clk), .RST(rst), .START(start), .LAP(lap), .CLR(clr),
    .CNT1(cnt1), .CNT10(cnt10), .CNT_EN(cnt_en), .CNT_CLR(cnt_clr),
    .DISP1(disp1), .DISP10(disp10), .RUNNING(running), .LAP_HOLD(lap_hold),
    .STATE(state)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BCD counter: clear has priority over count
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= 4'd0; cnt10 <= 4'd0;
    end else if (cnt_clr) begin
      cnt1 <= 4'd0; cnt10 <= 4'd0;
    end else if (cnt_en) begin
      if (cnt1 == 4'd9) begin
        cnt1  <= 4'd0;
        cnt10 <= (cnt10 == 4'd9) ? 4'd0 : cnt10 + 4'd1;
      end else begin
        cnt1 <= cnt1 + 4'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard: expected CNT_EN cycle numbers
  always @(negedge clk) begin
    if (cnt_en) n_ticks++;
    if (mon_en && cnt_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tick_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        check("tick_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) next_cycle();
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    start = s; lap = l; clr = c;
    next_cycle();
    start = 1'b0; lap = 1'b0; clr = 1'b0;
  endtask

  task automatic expect_ticks(input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(32'(first + k * DIV));
  endtask

  task automatic set_vec(input int i, input logic s, input logic l, input logic c,
                         input logic r, input logic h, input logic [1:0] st, input logic cc);
    vecs[i].s = s; vecs[i].l = l; vecs[i].c = c;
    vecs[i].run = r; vecs[i].hold = h; vecs[i].st = st; vecs[i].cc = cc;
  endtask

  initial begin
    int c0, s0, m0, r0, t0;

    //          s  l  c   run hold st cc
    set_vec(0,  0, 1, 0,  0,  0,  0, 0);
    set_vec(1,  0, 0, 1,  0,  0,  0, 1);
    set_vec(2,  1, 0, 0,  1,  0,  1, 0);
    set_vec(3,  0, 1, 0,  1,  1,  2, 0);
    set_vec(4,  0, 1, 0,  1,  0,  1, 0);
    set_vec(5,  0, 1, 0,  1,  1,  2, 0);
    set_vec(6,  1, 0, 0,  0,  0,  3, 0);
    set_vec(7,  0, 1, 0,  0,  0,  3, 0);
    set_vec(8,  1, 0, 0,  1,  0,  1, 0);
    set_vec(9,  1, 1, 0,  0,  0,  3, 0);
    set_vec(10, 1, 0, 0,  1,  0,  1, 0);
    set_vec(11, 1, 1, 1,  0,  0,  0, 1);
    set_vec(12, 1, 0, 0,  1,  0,  1, 0);
    set_vec(13, 0, 1, 0,  1,  1,  2, 0);
    set_vec(14, 0, 0, 1,  0,  0,  0, 1);
    set_vec(15, 1, 0, 0,  1,  0,  1, 0);
    set_vec(16, 1, 0, 0,  0,  0,  3, 0);
    set_vec(17, 0, 0, 1,  0,  0,  0, 1);

    // reset held two cycles, then quiet for 50 cycles
    next_cycle(); next_cycle();
    sample();
    check("rst_running", running, 0);
    check("rst_cnt_en", cnt_en, 0);
    next_cycle();
    rst = 1'b0;
    sample();
    check("post_rst_running", running, 0);
    check("post_rst_lap_hold", lap_hold, 0);
    check("post_rst_cnt_clr", cnt_clr, 0);
    check("post_rst_state", state, 0);
    check("post_rst_disp", {disp10, disp1}, 8'h00);
    mon_en = 1'b1;
    t0 = n_ticks;
    goto_cycle(cyc + 50);
    sample();
    check("rst_quiet_ticks", n_ticks - t0, 0);

    // transition table
    mon_en = 1'b0;
    next_cycle();
    for (int i = 0; i < 18; i++) begin
      press(vecs[i].s, vecs[i].l, vecs[i].c);
      sample();
      check($sformatf("vec%0d_running", i), running, vecs[i].run);
      check($sformatf("vec%0d_lap_hold", i), lap_hold, vecs[i].hold);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_cnt_clr", i), cnt_clr, vecs[i].cc);
      next_cycle();
    end
    next_cycle(); next_cycle();
    mon_en = 1'b1;

    // start and steady counting
    c0 = cyc;
    expect_ticks(c0 + 5, 10);
    press(1, 0, 0);
    sample();
    check("b_running", running, 1);
    goto_cycle(c0 + 42);
    sample();
    check("b_disp_10", {disp10, disp1}, 8'h10);
    check("b_ticks_done", exp_q.size(), 0);
    press(0, 0, 1);
    sample();
    check("b_clr_pulse", cnt_clr, 1);
    check("b_clr_state", state, 0);
    next_cycle();
    sample();
    check("b_clr_one_cycle", cnt_clr, 0);
    check("b_clr_disp", {disp10, disp1}, 8'h00);

    // lap freeze
    next_cycle();
    s0 = cyc;
    expect_ticks(s0 + 5, 9);
    press(1, 0, 0);
    goto_cycle(s0 + 14);
    sample();
    check("c_disp_03", {disp10, disp1}, 8'h03);
    press(0, 1, 0);
    sample();
    check("c_lap_hold", lap_hold, 1);
    check("c_frozen_03", {disp10, disp1}, 8'h03);
    goto_cycle(s0 + 34);
    sample();
    check("c_still_03", {disp10, disp1}, 8'h03);
    check("c_cnt_08", {cnt10, cnt1}, 8'h08);
    press(0, 1, 0);
    sample();
    check("c_hold_off", lap_hold, 0);
    check("c_live_08", {disp10, disp1}, 8'h08);
    check("c_running", running, 1);

    // stop at prescaler 2, resume
    goto_cycle(s0 + 39);
    press(1, 0, 0);
    sample();
    check("d_stop_state", state, 3);
    check("d_stop_running", running, 0);
    t0 = n_ticks;
    goto_cycle(s0 + 60);
    sample();
    check("d_silent_ticks", n_ticks - t0, 0);
    check("d_disp_09", {disp10, disp1}, 8'h09);
    m0 = cyc;
    expect_ticks(m0 + 3, 2);
    press(1, 0, 0);
    goto_cycle(m0 + 8);
    sample();
    check("d_resume_ticks", exp_q.size(), 0);
    check("d_disp_11", {disp10, disp1}, 8'h11);

    // CLR + START together in RUN
    goto_cycle(m0 + 9);
    press(1, 0, 1);
    sample();
    check("e_cnt_clr", cnt_clr, 1);
    check("e_state", state, 0);
    check("e_running", running, 0);
    next_cycle();
    sample();
    check("e_cnt_clr_once", cnt_clr, 0);
    check("e_disp_00", {disp10, disp1}, 8'h00);
    check("e_state_idle", state, 0);
    t0 = n_ticks;
    goto_cycle(m0 + 20);
    sample();
    check("e_no_ticks", n_ticks - t0, 0);

    // 99 boundary
    r0 = cyc;
`ifdef STOPWATCH_AUTOSTOP_EN
    expect_ticks(r0 + 5, 99);
`else
    expect_ticks(r0 + 5, 100);
`endif
    press(1, 0, 0);
    goto_cycle(r0 + 402);
    sample();
    check("f_ticks_done", exp_q.size(), 0);
`ifdef STOPWATCH_AUTOSTOP_EN
    check("f_state_stop", state, 3);
    check("f_running", running, 0);
    check("f_disp_99", {disp10, disp1}, 8'h99);
    t0 = n_ticks;
    goto_cycle(r0 + 422);
    sample();
    check("f_no_more_ticks", n_ticks - t0, 0);
    check("f_disp_held", {disp10, disp1}, 8'h99);
`else
    check("f_disp_wrap", {disp10, disp1}, 8'h00);
    check("f_running", running, 1);
`endif

    // reset mid-operation
    next_cycle();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("g_running", running, 0);
    check("g_lap_hold", lap_hold, 0);
    check("g_cnt_en", cnt_en, 0);
    check("g_cnt_clr", cnt_clr, 0);
    check("g_state", state, 0);
    check("g_disp", {disp10, disp1}, 8'h00);
    next_cycle(); next_cycle();
    rst = 1'b0;
    next_cycle();
    sample();
    check("g_after_state", state, 0);
    check("g_after_cnt_clr", cnt_clr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
